// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_bus_cond.sv
// Synchronises raw SCL/SDA and decodes SCL edges plus START/STOP conditions.
module i2c_bus_cond (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);

  logic r_scl_meta, r_scl_sync, r_scl_dly;
  logic r_sda_meta, r_sda_sync, r_sda_dly;

  // Idle bus level is high on both lines.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_dly  <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_dly  <= 1'b1;
    end else begin
      r_scl_meta <= i_scl;
      r_scl_sync <= r_scl_meta;
      r_scl_dly  <= r_scl_sync;
      r_sda_meta <= i_sda;
      r_sda_sync <= r_sda_meta;
      r_sda_dly  <= r_sda_sync;
    end
  end

  assign o_scl_rise = r_scl_sync & ~r_scl_dly;
  assign o_scl_fall = ~r_scl_sync & r_scl_dly;
  assign o_start    = r_scl_sync & r_scl_dly & r_sda_dly & ~r_sda_sync;
  assign o_stop     = r_scl_sync & r_scl_dly & ~r_sda_dly & r_sda_sync;
  assign o_sda      = r_sda_sync;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with a byte-wide register bank: pointer+data writes, auto-incrementing reads.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h2A,
  parameter int         NUM_REGS  = 4,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_scl,
  input  logic                        i_sda,
  output logic                        o_sda_oe,
  output logic                        o_busy,
  output logic                        o_wr_stb,
  output logic [$clog2(NUM_REGS)-1:0] o_wr_idx,
  output logic [7:0]                  o_wr_data,
  output logic [8*NUM_REGS-1:0]       o_regs
);

  localparam int IW = $clog2(NUM_REGS);
  localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
  logic [7:0] w_rd_data;

  state_t        r_state;
  logic [7:0]    r_shift;
  logic [3:0]    r_bit_cnt;
  logic [IW-1:0] r_ptr;
  logic          r_ptr_byte;
  logic          r_nack;
  logic          r_sda_oe, r_busy, r_wr_stb;
  logic [IW-1:0] r_wr_idx;
  logic [7:0]    r_wr_data;
  logic [7:0]    r_regs [NUM_REGS];

  i2c_bus_cond u_bus_cond (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_sda      (w_sda)
  );

  assign w_rd_data = r_regs[r_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 4'd0;
      r_ptr      <= '0;
      r_ptr_byte <= 1'b0;
      r_nack     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_stb   <= 1'b0;
      r_wr_idx   <= '0;
      r_wr_data  <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_start) begin
        r_state   <= ADDR;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state  <= IDLE;
        r_busy   <= 1'b0;
        r_sda_oe <= 1'b0;
      end else begin
        case (r_state)
          ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == LAST_BIT) begin
              if (r_shift[7:1] == DEV_ADDR) begin
                r_state  <= ADDR_ACK;
                r_sda_oe <= 1'b1;
                r_busy   <= 1'b1;
              end else begin
                r_state <= IGNORE;
                r_busy  <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            // r_shift[0] still holds the R/W bit of the address byte.
            if (w_scl_fall) begin
              if (!r_shift[0]) begin
                r_state    <= WR_BYTE;
                r_bit_cnt  <= 4'd0;
                r_ptr_byte <= 1'b1;
                r_sda_oe   <= 1'b0;
              end else begin
                r_state   <= RD_BYTE;
                r_shift   <= w_rd_data;
                r_bit_cnt <= 4'd1;
                r_sda_oe  <= ~w_rd_data[7];
              end
            end
          end
          WR_BYTE: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == LAST_BIT) begin
              r_state  <= WR_ACK;
              r_sda_oe <= 1'b1;
              if (r_ptr_byte) begin
                r_ptr      <= r_shift[IW-1:0];
                r_ptr_byte <= 1'b0;
              end else begin
                r_regs[r_ptr] <= r_shift;
                r_wr_stb      <= 1'b1;
                r_wr_idx      <= r_ptr;
                r_wr_data     <= r_shift;
                r_ptr         <= r_ptr + IW'(1);
              end
            end
          end
          WR_ACK: begin
            if (w_scl_fall) begin
              r_state   <= WR_BYTE;
              r_bit_cnt <= 4'd0;
              r_sda_oe  <= 1'b0;
            end
          end
          RD_BYTE: begin
            // r_bit_cnt counts bits already presented; the MSB went out on entry.
            if (w_scl_fall) begin
              if (r_bit_cnt == LAST_BIT) begin
                r_state  <= RD_ACK;
                r_sda_oe <= 1'b0;
              end else begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_sda_oe  <= ~r_shift[6];
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (w_scl_rise) begin
              r_nack <= w_sda;
              r_ptr  <= r_ptr + IW'(1);
            end else if (w_scl_fall) begin
              if (r_nack) begin
                r_state <= IGNORE;
                r_busy  <= 1'b0;
              end else begin
                r_state   <= RD_BYTE;
                r_shift   <= w_rd_data;
                r_bit_cnt <= 4'd1;
                r_sda_oe  <= ~w_rd_data[7];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign o_regs[8*g +: 8] = r_regs[g];
  end

  assign o_sda_oe  = r_sda_oe;
  assign o_busy    = r_busy;
  assign o_wr_stb  = r_wr_stb;
  assign o_wr_idx  = r_wr_idx;
  assign o_wr_data = r_wr_data;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: a bit-banged open-drain master plus inline checks.
module tb_i2c_reg_target;

  localparam int Q = 8;  // quarter SCL period in clocks

  logic        clk;
  logic        rst_n;
  logic        m_scl;
  logic        m_sda;
  logic        sda_bus;
  logic        oe;
  logic        busy;
  logic        wr_stb;
  logic [1:0]  wr_idx;
  logic [7:0]  wr_data;
  logic [31:0] regs;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] q_idx[$];
  logic [7:0] q_data[$];
  int         oe_cnt   = 0;
  int         busy_cnt = 0;

  assign sda_bus = m_sda & ~oe;

  i2c_reg_target #(
    .DEV_ADDR  (7'h2A),
    .NUM_REGS  (4),
    .RESET_VAL (8'h00)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_scl     (m_scl),
    .i_sda     (sda_bus),
    .o_sda_oe  (oe),
    .o_busy    (busy),
    .o_wr_stb  (wr_stb),
    .o_wr_idx  (wr_idx),
    .o_wr_data (wr_data),
    .o_regs    (regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) begin
      q_idx.push_back(wr_idx);
      q_data.push_back(wr_data);
    end
    if (oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(2 * Q);
    m_sda = 1'b0; wait_clk(2 * Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(2 * Q);
    m_sda = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wait_clk(Q);
    m_scl = 1'b1; wait_clk(2 * Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    ack = sda_bus; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    b = 8'h00;
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_clk(Q);
      m_scl = 1'b1; wait_clk(Q);
      b = {b[6:0], sda_bus}; wait_clk(Q);
      m_scl = 1'b0; wait_clk(Q);
    end
    send_bit(nack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
    wait_clk(4);
    @(negedge clk);
    n_tests++; if (oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", oe); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (wr_stb !== 1'b0 || wr_idx !== 2'd0 || wr_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_wr: got stb=%b idx=%0d data=%h want 0/0/00", wr_stb, wr_idx, wr_data);
    end
    n_tests++; if (regs !== 32'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 00000000", regs); end
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_write_wrap();
    logic [7:0] bytes [4] = '{8'h54, 8'h01, 8'hA5, 8'h3C};
    logic ack;
    int base = q_idx.size();
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], ack);
      n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack%0d: got %b want 0", i, ack); end
    end
    @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_mid: got %b want 1", busy); end
    i2c_stop();
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
    n_tests++; if (regs[15:8] !== 8'hA5 || regs[23:16] !== 8'h3C) begin
      n_fail++; $display("FAIL wr_regs: got r1=%h r2=%h want A5 3C", regs[15:8], regs[23:16]);
    end
    n_tests++; if (q_idx.size() - base !== 2) begin
      n_fail++; $display("FAIL wr_stb_count: got %0d want 2", q_idx.size() - base);
    end else begin
      n_tests++; if (q_idx[base] !== 2'd1 || q_data[base] !== 8'hA5 ||
                     q_idx[base+1] !== 2'd2 || q_data[base+1] !== 8'h3C) begin
        n_fail++; $display("FAIL wr_stb_vals: got %0d/%h %0d/%h want 1/A5 2/3C",
                           q_idx[base], q_data[base], q_idx[base+1], q_data[base+1]);
      end
    end
  endtask

  task automatic test_ptr_wrap();
    logic ack;
    logic [7:0] rd;
    int base = q_idx.size();
    i2c_start();
    write_byte(8'h54, ack); write_byte(8'h03, ack);
    write_byte(8'h11, ack); write_byte(8'h22, ack);
    i2c_stop();
    n_tests++; if (regs[31:24] !== 8'h11 || regs[7:0] !== 8'h22) begin
      n_fail++; $display("FAIL ptr_wrap_regs: got r3=%h r0=%h want 11 22", regs[31:24], regs[7:0]);
    end
    n_tests++; if (q_idx.size() - base !== 2 || q_idx[base+1] !== 2'd0) begin
      n_fail++; $display("FAIL ptr_wrap_idx: got n=%0d want 2 with second idx 0", q_idx.size() - base);
    end
    // Pointer byte 0x07 truncates to 3; a current-address read then returns regs[3].
    i2c_start(); write_byte(8'h54, ack); write_byte(8'h07, ack); i2c_stop();
    i2c_start(); write_byte(8'h55, ack); read_byte(rd, 1'b1); i2c_stop();
    n_tests++; if (rd !== 8'h11) begin n_fail++; $display("FAIL ptr_trunc: got %h want 11", rd); end
  endtask

  task automatic test_rs_read();
    logic ack;
    logic [7:0] b0, b1, b2;
    i2c_start();
    write_byte(8'h54, ack); write_byte(8'h01, ack);
    i2c_start();
    write_byte(8'h55, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_addr_ack: got %b want 0", ack); end
    read_byte(b0, 1'b0);
    read_byte(b1, 1'b1);
    @(negedge clk);
    n_tests++; if (oe !== 1'b0) begin n_fail++; $display("FAIL rs_oe_after_nack: got %b want 0", oe); end
    i2c_stop();
    n_tests++; if (b0 !== 8'hA5 || b1 !== 8'h3C) begin
      n_fail++; $display("FAIL rs_data: got %h %h want A5 3C", b0, b1);
    end
    // Pointer now 3: current-address read yields regs[3].
    i2c_start(); write_byte(8'h55, ack); read_byte(b2, 1'b1); i2c_stop();
    n_tests++; if (b2 !== 8'h11) begin n_fail++; $display("FAIL rs_ptr_after: got %h want 11", b2); end
  endtask

  task automatic test_addr_mismatch();
    logic ack0, ack1;
    int base = q_idx.size();
    int oe0 = oe_cnt;
    int busy0 = busy_cnt;
    i2c_start(); write_byte(8'h56, ack0); write_byte(8'hFF, ack1); i2c_stop();
    n_tests++; if (ack0 !== 1'b1 || ack1 !== 1'b1) begin
      n_fail++; $display("FAIL mis_ack: got %b %b want 1 1", ack0, ack1);
    end
    n_tests++; if (oe_cnt != oe0 || busy_cnt != busy0) begin
      n_fail++; $display("FAIL mis_oe_busy: got oe_cycles=%0d busy_cycles=%0d want 0 0",
                         oe_cnt - oe0, busy_cnt - busy0);
    end
    n_tests++; if (regs !== 32'h113CA522 || q_idx.size() != base) begin
      n_fail++; $display("FAIL mis_regs: got %h stb=%0d want 113CA522 stb=0", regs, q_idx.size() - base);
    end
  endtask

  task automatic test_abort();
    logic ack;
    int base = q_idx.size();
    i2c_start(); write_byte(8'h54, ack); write_byte(8'h00, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    @(negedge clk);
    n_tests++; if (regs !== 32'h113CA522 || q_idx.size() != base || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort: got regs=%h stb=%0d busy=%b want 113CA522 0 0",
                         regs, q_idx.size() - base, busy);
    end
    i2c_start(); write_byte(8'h54, ack); write_byte(8'h00, ack); write_byte(8'h5A, ack); i2c_stop();
    n_tests++; if (regs[7:0] !== 8'h5A || ack !== 1'b0) begin
      n_fail++; $display("FAIL abort_recover: got r0=%h ack=%b want 5A 0", regs[7:0], ack);
    end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    bit seen = 1'b0;
    i2c_start(); write_byte(8'h55, ack);
    // regs[1]=A5: first bit 1 (released), second bit 0 (driven).
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(2 * Q);
    m_scl = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (oe) seen = 1'b1;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL rst_read_drive: got oe=0 want 1 within 20 clks"); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (oe !== 1'b0 || regs !== 32'h0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: got oe=%b busy=%b regs=%h want 0 0 00000000", oe, busy, regs);
    end
    m_sda = 1'b1; wait_clk(2);
    m_scl = 1'b1; wait_clk(4);
    rst_n = 1'b1; wait_clk(4);
    i2c_start();
    write_byte(8'h54, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_after_ack: got %b want 0", ack); end
    write_byte(8'h02, ack); write_byte(8'h77, ack);
    i2c_stop();
    n_tests++; if (regs !== 32'h00770000) begin
      n_fail++; $display("FAIL rst_after_write: got %h want 00770000", regs);
    end
  endtask

  initial begin
    test_reset();
    test_write_wrap();
    test_ptr_wrap();
    test_rs_read();
    test_addr_mismatch();
    test_abort();
    test_reset_mid_read();
    wait_clk(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
